// File: rtl/geofence_nv.sv
// Convex geofence engine: loads NV vertices and a query point, sorts the vertices CCW around P0,
// then tests the point against every edge. Optional macro GEOFENCE_AREA_EN adds the area2 output.
module geofence_nv #(
    parameter int CW          = 10,
    parameter int NV          = 6,
    parameter int EDGE_INSIDE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [CW-1:0]             X,
    input  logic [CW-1:0]             Y,
    output logic                      busy,
    output logic                      valid,
    output logic                      is_inside
`ifdef GEOFENCE_AREA_EN
    ,
    output logic [2*CW+$clog2(NV):0]  area2
`endif
);

    localparam int IW    = $clog2(NV);
    localparam int CNTW  = $clog2(NV + 1);
    localparam int NSORT = (NV - 2) * (NV - 2);
    localparam int SW    = $clog2(NSORT + 1);
    localparam int XW    = 2 * CW + 3;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SORT, S_TEST, S_DONE} state_t;

    state_t            r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [SW-1:0]     r_step;
    logic [IW-1:0]     r_j;
    logic [IW-1:0]     r_k;
    logic              r_fail;
    logic              r_busy;
    logic              r_valid;
    logic              r_inside;

    logic [CW-1:0]     r_px [NV];
    logic [CW-1:0]     r_py [NV];
    logic [CW-1:0]     r_qx;
    logic [CW-1:0]     r_qy;

    logic [IW-1:0]     w_j1;
    logic [IW-1:0]     w_k1;
    logic [IW-1:0]     w_widx;
    logic              w_take;
    logic              w_swap;
    logic              w_edge_fail;
    logic signed [XW-1:0] w_c_sort;
    logic signed [XW-1:0] w_e;

    // (a - o) x (b - o) at full precision: CW+1 differences, 2*CW+2 products, 2*CW+3 result.
    function automatic logic signed [XW-1:0] cross3(
        input logic [CW-1:0] ox, input logic [CW-1:0] oy,
        input logic [CW-1:0] ax, input logic [CW-1:0] ay,
        input logic [CW-1:0] bx, input logic [CW-1:0] by
    );
        logic signed [CW:0]       dax, day, dbx, dby;
        logic signed [2*CW+1:0]   p1, p2;
        dax = $signed({1'b0, ax}) - $signed({1'b0, ox});
        day = $signed({1'b0, ay}) - $signed({1'b0, oy});
        dbx = $signed({1'b0, bx}) - $signed({1'b0, ox});
        dby = $signed({1'b0, by}) - $signed({1'b0, oy});
        p1  = dax * dby;
        p2  = day * dbx;
        return $signed({p1[2*CW+1], p1}) - $signed({p2[2*CW+1], p2});
    endfunction

    always_comb begin
        w_j1        = r_j + IW'(1);
        w_k1        = (r_k == IW'(NV - 1)) ? '0 : r_k + IW'(1);
        w_take      = in_valid && (r_state == S_IDLE || r_state == S_DONE || r_state == S_LOAD);
        w_widx      = (r_state == S_LOAD) ? r_cnt[IW-1:0] : '0;
        w_c_sort    = cross3(r_px[0], r_py[0], r_px[r_j], r_py[r_j], r_px[w_j1], r_py[w_j1]);
        w_swap      = (r_state == S_SORT) && w_c_sort[XW-1];
        w_e         = cross3(r_px[r_k], r_py[r_k], r_px[w_k1], r_py[w_k1], r_qx, r_qy);
        w_edge_fail = w_e[XW-1] || ((w_e == '0) && (EDGE_INSIDE == 0));
    end

`ifdef GEOFENCE_AREA_EN
    localparam int AW = 2 * CW + 2 + $clog2(NV);
    logic signed [AW-1:0] r_acc;
    logic [2*CW-1:0]      w_m1;
    logic [2*CW-1:0]      w_m2;
    logic signed [AW-1:0] w_term;

    always_comb begin
        w_m1   = r_px[r_k] * r_py[w_k1];
        w_m2   = r_px[w_k1] * r_py[r_k];
        w_term = $signed(AW'(w_m1)) - $signed(AW'(w_m2));
    end
`endif

    // NOTE: vertex storage has no reset; the beat counter alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_take) begin
            if (r_state == S_LOAD && r_cnt == CNTW'(NV)) begin
                r_qx <= X;
                r_qy <= Y;
            end else begin
                r_px[w_widx] <= X;
                r_py[w_widx] <= Y;
            end
        end else if (w_swap) begin
            r_px[r_j]  <= r_px[w_j1];
            r_py[r_j]  <= r_py[w_j1];
            r_px[w_j1] <= r_px[r_j];
            r_py[w_j1] <= r_py[r_j];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_step   <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_fail   <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_inside <= 1'b0;
`ifdef GEOFENCE_AREA_EN
            r_acc    <= '0;
            area2    <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_DONE) begin
                        r_valid  <= 1'b1;
                        r_inside <= !r_fail;
`ifdef GEOFENCE_AREA_EN
                        area2    <= r_acc[2*CW+$clog2(NV):0];
`endif
                    end
                    // A beat in DONE starts the next set immediately.
                    if (in_valid) begin
                        r_cnt   <= CNTW'(1);
                        r_state <= S_LOAD;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (r_cnt == CNTW'(NV)) begin
                            r_state <= S_SORT;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_step  <= '0;
                            r_j     <= IW'(1);
                            r_fail  <= 1'b0;
`ifdef GEOFENCE_AREA_EN
                            r_acc   <= '0;
`endif
                        end else begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                    end
                end
                S_SORT: begin
                    r_step <= r_step + SW'(1);
                    r_j    <= (r_j == IW'(NV - 2)) ? IW'(1) : w_j1;
                    if (r_step == SW'(NSORT - 1)) begin
                        r_state <= S_TEST;
                        r_k     <= '0;
                    end
                end
                S_TEST: begin
                    r_fail <= r_fail | w_edge_fail;
`ifdef GEOFENCE_AREA_EN
                    r_acc  <= r_acc + w_term;
`endif
                    r_k    <= w_k1;
                    if (r_k == IW'(NV - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign valid     = r_valid;
    assign is_inside = r_inside;

endmodule

// File: tb/tb_geofence_nv.sv
// Directed bench for geofence_nv: hexagon (NV=6, both boundary modes) and triangle (NV=3, CW=8).
module tb_geofence_nv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid6;
    logic [9:0] x6, y6;
    logic       busy_a, valid_a, ins_a;
    logic       busy_b, valid_b, ins_b;
    logic       in_valid3;
    logic [7:0] x3, y3;
    logic       busy_c, valid_c, ins_c;
`ifdef GEOFENCE_AREA_EN
    logic [23:0] area_a, area_b;
    logic [18:0] area_c;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] hx [6] = '{10'd100, 10'd200, 10'd50, 10'd250, 10'd100, 10'd200};
    logic [9:0] hy [6] = '{10'd0, 10'd200, 10'd100, 10'd100, 10'd200, 10'd0};
    logic [7:0] tx [3] = '{8'd0, 8'd0, 8'd200};
    logic [7:0] ty [3] = '{8'd0, 8'd200, 8'd0};

    geofence_nv #(.CW(10), .NV(6), .EDGE_INSIDE(1)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid6), .X(x6), .Y(y6),
        .busy(busy_a), .valid(valid_a), .is_inside(ins_a)
`ifdef GEOFENCE_AREA_EN
        , .area2(area_a)
`endif
    );

    geofence_nv #(.CW(10), .NV(6), .EDGE_INSIDE(0)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid6), .X(x6), .Y(y6),
        .busy(busy_b), .valid(valid_b), .is_inside(ins_b)
`ifdef GEOFENCE_AREA_EN
        , .area2(area_b)
`endif
    );

    geofence_nv #(.CW(8), .NV(3), .EDGE_INSIDE(1)) u_c (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .X(x3), .Y(y3),
        .busy(busy_c), .valid(valid_c), .is_inside(ins_c)
`ifdef GEOFENCE_AREA_EN
        , .area2(area_c)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat6(input logic [9:0] x, input logic [9:0] y);
        in_valid6 = 1'b1; x6 = x; y6 = y;
        tick();
        in_valid6 = 1'b0;
    endtask

    task automatic beat3(input logic [7:0] x, input logic [7:0] y);
        in_valid3 = 1'b1; x3 = x; y3 = y;
        tick();
        in_valid3 = 1'b0;
    endtask

    // Loads the hexagon then Q; returns just after t0. stall_at inserts a 3-cycle gap.
    task automatic load6(input logic [9:0] qx, input logic [9:0] qy, input int stall_at);
        for (int i = 0; i < 6; i++) begin
            if (i == stall_at) repeat (3) tick();
            beat6(hx[i], hy[i]);
        end
        beat6(qx, qy);
    endtask

    task automatic load3(input logic [7:0] qx, input logic [7:0] qy);
        for (int i = 0; i < 3; i++) beat3(tx[i], ty[i]);
        beat3(qx, qy);
    endtask

    // Counts edges after t0 until valid; optional junk beats while the engine is busy.
    task automatic wait6(input bit noise, output int lat);
        lat = 0;
        do begin
            if (noise) begin
                in_valid6 = busy_a;
                x6 = 10'($urandom);
                y6 = 10'($urandom);
            end
            tick();
            lat++;
        end while (!valid_a && lat < 60);
        in_valid6 = 1'b0;
    endtask

    task automatic wait3(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!valid_c && lat < 60);
    endtask

    task automatic run6(input string tag, input logic [9:0] qx, input logic [9:0] qy,
                        input int stall_at, input bit noise, input bit exp_a, input bit exp_b);
        int lat;
        load6(qx, qy, stall_at);
        check({tag, "_busy"}, busy_a, 1);
        wait6(noise, lat);
        check({tag, "_lat"}, lat, 23);
        check({tag, "_valid_b"}, valid_b, 1);
        check({tag, "_ins_a"}, ins_a, exp_a);
        check({tag, "_ins_b"}, ins_b, exp_b);
        tick();
        check({tag, "_pulse"}, valid_a, 0);
    endtask

    initial begin
        int lat;
        int pulses;
        reset = 1'b1;
        in_valid6 = 1'b0; x6 = '0; y6 = '0;
        in_valid3 = 1'b0; x3 = '0; y3 = '0;
        repeat (2) tick();
        check("rst_busy", busy_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_inside", ins_a, 0);
`ifdef GEOFENCE_AREA_EN
        check("rst_area", area_a, 0);
`endif
        reset = 1'b0;
        tick();

        run6("hex_in", 10'd150, 10'd100, -1, 1'b0, 1'b1, 1'b1);
`ifdef GEOFENCE_AREA_EN
        check("hex_area", area_a, 60000);
`endif
        run6("hex_out_r", 10'd300, 10'd100, -1, 1'b0, 1'b0, 1'b0);
        run6("hex_origin", 10'd0, 10'd0, -1, 1'b0, 1'b0, 1'b0);
        run6("hex_edge", 10'd150, 10'd0, -1, 1'b0, 1'b1, 1'b0);

        // Reset in the fifth SORT cycle must swallow the result.
        load6(10'd150, 10'd100, -1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy_a, 0);
        check("abort_inside", ins_a, 0);
        pulses = 0;
        repeat (40) begin
            tick();
            if (valid_a) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        run6("after_abort", 10'd150, 10'd100, -1, 1'b0, 1'b1, 1'b1);

        run6("noise_stall", 10'd150, 10'd100, 3, 1'b1, 1'b1, 1'b1);
        run6("noise_out", 10'd300, 10'd100, 2, 1'b1, 1'b0, 1'b0);

        load3(8'd50, 8'd50);
        wait3(lat);
        check("tri_lat", lat, 5);
        check("tri_in", ins_c, 1);
`ifdef GEOFENCE_AREA_EN
        check("tri_area", area_c, 40000);
`endif
        tick();

        // First set ends outside; its DONE cycle carries P0 of the next set.
        load3(8'd150, 8'd150);
        pulses = 0;
        repeat (4) begin
            tick();
            if (valid_c) pulses++;
        end
        check("tri_early", pulses, 0);
        check("tri_done_idle", busy_c, 0);
        beat3(tx[0], ty[0]);
        check("tri_out_valid", valid_c, 1);
        check("tri_out", ins_c, 0);
        beat3(tx[1], ty[1]);
        beat3(tx[2], ty[2]);
        beat3(8'd50, 8'd50);
        wait3(lat);
        check("tri_chain_lat", lat, 5);
        check("tri_chain_in", ins_c, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
